// File: rtl/cordic_scheduler.sv
// Round-robin front end that time-shares one cordic core between NREQ clients.
// One job in flight at a time; the response sits in a single-entry buffer until consumed.
module cordic_scheduler #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int LATENCY = 16,
    parameter int IDW     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_mode,
    input  logic [NREQ*W-1:0]   req_x,
    input  logic [NREQ*W-1:0]   req_y,
    input  logic [NREQ*W-1:0]   req_z,
    output logic                cor_mode,
    output logic [W-1:0]        cor_x,
    output logic [W-1:0]        cor_y,
    output logic [W-1:0]        cor_z,
    output logic                cor_start,
    input  logic [W-1:0]        cor_res1,
    input  logic [W-1:0]        cor_res2,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_res1,
    output logic [W-1:0]        rsp_res2,
    output logic                busy
);

    // state | meaning
    // IDLE  | no job in flight, arbitrating among req_valid
    // RUN   | operands held on the core, latency down-counter running
    // DONE  | result captured, waiting for rsp_ready
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] cur_id;

    logic           grant_vld;
    logic [IDW-1:0] grant;
    logic           hi_found;
    logic           lo_found;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;

    logic           accept;
    logic           finish;

    logic           sel_mode;
    logic [W-1:0]   sel_x;
    logic [W-1:0]   sel_y;
    logic [W-1:0]   sel_z;

    // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IDW'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDW'(i);
                end
            end
        end
        grant_vld = hi_found | lo_found;
        grant     = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_mode = 1'b0;
        sel_x    = '0;
        sel_y    = '0;
        sel_z    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_mode = req_mode[i];
                sel_x    = req_x[i*W +: W];
                sel_y    = req_y[i*W +: W];
                sel_z    = req_z[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_nxt        = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CW'(1)) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            last_grant <= IDW'(NREQ - 1);
            cur_id     <= '0;
            cor_mode   <= 1'b0;
            cor_x      <= '0;
            cor_y      <= '0;
            cor_z      <= '0;
            cor_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_res1   <= '0;
            rsp_res2   <= '0;
        end else begin
            cor_start <= accept;
            if (accept) begin
                cor_mode   <= sel_mode;
                cor_x      <= sel_x;
                cor_y      <= sel_y;
                cor_z      <= sel_z;
                cur_id     <= grant;
                last_grant <= grant;
                cnt        <= CW'(LATENCY);
            end else if (state == S_RUN) begin
                cnt <= cnt - CW'(1);
            end
            // Response data is left in place after the handshake; only the valid drops.
            if (finish) begin
                rsp_valid <= 1'b1;
                rsp_id    <= cur_id;
                rsp_res1  <= cor_res1;
                rsp_res2  <= cor_res2;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: behavioural core, scoreboard of expected responses,
// grant-order, timing and stability checks.
module tb_cordic_scheduler;
    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int LAT  = 16;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_mode;
    logic [NREQ*W-1:0]   req_x;
    logic [NREQ*W-1:0]   req_y;
    logic [NREQ*W-1:0]   req_z;
    logic                cor_mode;
    logic [W-1:0]        cor_x;
    logic [W-1:0]        cor_y;
    logic [W-1:0]        cor_z;
    logic                cor_start;
    logic [W-1:0]        cor_res1;
    logic [W-1:0]        cor_res2;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_res1;
    logic [W-1:0]        rsp_res2;
    logic                busy;

    logic [W-1:0] opx [NREQ];
    logic [W-1:0] opy [NREQ];
    logic [W-1:0] opz [NREQ];
    logic         opm [NREQ];

    always #5 clk = ~clk;

    cordic_scheduler #(.NREQ(NREQ), .W(W), .LATENCY(LAT), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .cor_mode(cor_mode), .cor_x(cor_x), .cor_y(cor_y), .cor_z(cor_z),
        .cor_start(cor_start), .cor_res1(cor_res1), .cor_res2(cor_res2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res1(rsp_res1), .rsp_res2(rsp_res2), .busy(busy)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*W +: W] = opx[i];
            req_y[i*W +: W] = opy[i];
            req_z[i*W +: W] = opz[i];
            req_mode[i]     = opm[i];
        end
    end

    // Core model: garbage until LAT-1 cycles after the start pulse.
    int  age = 1000;
    logic core_ok;
    always @(posedge clk) age <= cor_start ? 1 : ((age < 1000) ? age + 1 : age);
    assign core_ok  = !cor_start && (age >= LAT - 1);
    assign cor_res1 = core_ok ? (cor_x ^ cor_z) : 16'hDEAD;
    assign cor_res2 = core_ok ? (cor_y + cor_z) : 16'hBEEF;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
    } exp_t;

    exp_t sb[$];
    int   grant_q[$];
    int   acc_cyc_q[$];
    int   cyc = 0;
    int   n_acc = 0;
    int   n_rsp = 0;
    int   n_start = 0;
    int   last_acc_cyc = 0;
    int   last_hs_cyc = 0;
    int   start_due = -1;
    int   pend_g = 0;
    logic rst_prev = 1'b1;
    logic rsp_v_prev = 1'b0;
    logic [48:0] cor_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            start_due = -1;
        end else begin
            if ((req_valid & req_ready) != '0) begin
                int   g;
                exp_t e;
                g = 0;
                for (int i = 0; i < NREQ; i++)
                    if (req_valid[i] && req_ready[i]) g = i;
                chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
                chk("ready_not_busy", busy, 1'b0);
                e.id = g;
                e.r1 = opx[g] ^ opz[g];
                e.r2 = opy[g] + opz[g];
                sb.push_back(e);
                grant_q.push_back(g);
                acc_cyc_q.push_back(cyc);
                last_acc_cyc = cyc;
                start_due    = cyc + 1;
                pend_g       = g;
                n_acc++;
            end
            if (cor_start) begin
                n_start++;
                chk("start_cycle", cyc, start_due);
                chk("cor_x", cor_x, opx[pend_g]);
                chk("cor_y", cor_y, opy[pend_g]);
                chk("cor_z", cor_z, opz[pend_g]);
                chk("cor_mode", cor_mode, opm[pend_g]);
            end else if (!rst_prev) begin
                chk("cor_hold", {cor_mode, cor_x, cor_y, cor_z}, cor_prev);
            end
            if (rsp_valid && !rsp_v_prev)
                chk("rsp_latency", cyc - last_acc_cyc, LAT + 1);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_res1", rsp_res1, e.r1);
                    chk("rsp_res2", rsp_res2, e.r2);
                end
                last_hs_cyc = cyc;
                n_rsp++;
            end
        end
        rst_prev   = reset;
        rsp_v_prev = rsp_valid;
        cor_prev   = {cor_mode, cor_x, cor_y, cor_z};
    end

    task automatic wait_acc(input int target);
        int budget;
        budget = 8 * (LAT + 2) + 50;
        while (n_acc < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("accept_wait", n_acc, target);
    endtask

    task automatic wait_rsp(input int target);
        int budget;
        budget = 8 * (LAT + 2) + 50;
        while (n_rsp < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("rsp_wait", n_rsp, target);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rbase;
        logic [IDW+2*W-1:0] snap;

        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            opx[i] = '0; opy[i] = '0; opz[i] = '0; opm[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cor_start", cor_start, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_cor_x", cor_x, '0);
        chk("rst_rsp_res1", rsp_res1, '0);

        // single job from req0
        opx[0] = 16'h9994; opy[0] = 16'h9EC1; opz[0] = 16'h01DF; opm[0] = 1'b1;
        @(posedge clk); #1 req_valid = 4'b0001;
        wait_acc(1);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(1);
        chk("single_res1", rsp_res1, 16'h984B);
        chk("single_res2", rsp_res2, 16'hA0A0);

        // fairness from reset: 0,1,2,3,0 at one job per LAT+2 cycles
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            opx[i] = 16'($urandom); opy[i] = 16'($urandom);
            opz[i] = 16'($urandom); opm[i] = 1'($urandom);
        end
        base  = n_acc;
        rbase = n_rsp;
        @(posedge clk); #1 req_valid = 4'b1111;
        wait_acc(base + 5);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(rbase + 5);
        for (int k = 0; k < 5; k++) begin
            if (grant_q.size() > base + k) chk("fair_grant", grant_q[base + k], k % NREQ);
            else chk("fair_grant_missing", grant_q.size(), base + k + 1);
        end
        for (int k = 1; k < 5; k++) begin
            if (acc_cyc_q.size() > base + k)
                chk("throughput", acc_cyc_q[base + k] - acc_cyc_q[base + k - 1], LAT + 2);
        end

        // backpressure on a req2 job, with req1 waiting behind it
        opx[2] = 16'($urandom); opy[2] = 16'($urandom); opz[2] = 16'($urandom);
        opx[1] = 16'($urandom); opy[1] = 16'($urandom); opz[1] = 16'($urandom);
        base  = n_acc;
        rbase = n_rsp;
        rsp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 4'b0100;
        wait_acc(base + 1);
        @(posedge clk); #1 req_valid = 4'b0010;
        for (int k = 0; k < LAT + 10 && !rsp_valid; k++) @(negedge clk);
        chk("bp_rsp_seen", rsp_valid, 1'b1);
        snap = {rsp_id, rsp_res1, rsp_res2};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_rsp_stable", {rsp_id, rsp_res1, rsp_res2}, snap);
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_busy", busy, 1'b1);
            chk("bp_req_ready", req_ready, '0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_acc(base + 2);
        chk("bp_bubble", last_acc_cyc - last_hs_cyc, 1);
        chk("wrap_grant", grant_q[grant_q.size() - 1], 1);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(rbase + 2);

        // reset while cnt==5, then req0 must win over req1
        opx[0] = 16'($urandom); opy[0] = 16'($urandom); opz[0] = 16'($urandom);
        base = n_acc;
        @(posedge clk); #1 req_valid = 4'b0001;
        wait_acc(base + 1);
        @(posedge clk); #1 req_valid = '0;
        repeat (11) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        rbase = n_rsp;
        repeat (LAT + 10) @(negedge clk);
        chk("abort_no_rsp", n_rsp, rbase);
        @(posedge clk); #1 req_valid = 4'b0011;
        wait_acc(base + 2);
        chk("post_reset_grant", grant_q[grant_q.size() - 1], 0);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(rbase + 1);

        repeat (3) @(negedge clk);
        chk("start_count", n_start, n_acc);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
